// File: rtl/kmap_resp_checker.sv
// rtl/kmap_resp_checker.sv - exhaustive response checker for the 4-in/3-out kmap logic block
//
// Purpose:
//   Walks the kmap block through all 16 input vectors ABCD = 0..15 in
//   ascending order. Each vector is held for SETTLE_CYC cycles and then
//   sampled in a CHECK cycle. F_0/F_1/F_2 are compared against the expected
//   truth tables under per-output care masks. The block reports the failing
//   vector count, the first failing vector with its mismatch bits, and a
//   pass flag.
//
// Ports:
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   start         in   run request; ignored while busy
//   A,B,C,D       out  kmap inputs, vector bits 3..0
//   F_0,F_1,F_2   in   kmap outputs
//   busy          out  run in progress
//   done          out  run complete (level, held until next start)
//   pass          out  done with no failing vectors
//   err_cnt       out  number of failing vectors, 0..16
//   first_err_vld out  at least one failing vector recorded
//   first_err_idx out  index of first failing vector
//   err_bits      out  {F_2,F_1,F_0} mismatch bits of first failing vector

module kmap_resp_checker #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [15:0] EXP_F0     = 16'h6996,
  parameter logic [15:0] EXP_F1     = 16'hEDE0,
  parameter logic [15:0] EXP_F2     = 16'hD1CC,
  parameter logic [15:0] CARE_F0    = 16'hFFFF,
  parameter logic [15:0] CARE_F1    = 16'hFFFF,
  parameter logic [15:0] CARE_F2    = 16'hDDDD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  input  logic       F_0,
  input  logic       F_1,
  input  logic       F_2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic       first_err_vld,
  output logic [3:0] first_err_idx,
  output logic [2:0] err_bits
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Final settle count before sampling; SETTLE_CYC is limited to 1..15.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  // 16 failures is the maximum possible, so the counter saturates there.
  localparam logic [4:0] ERR_MAX     = 5'd16;

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic [3:0] settle_cnt, settle_cnt_nxt;
  logic [3:0] vec_q, vec_nxt;
  logic [4:0] err_cnt_nxt;
  logic       first_err_vld_nxt;
  logic [3:0] first_err_idx_nxt;
  logic [2:0] err_bits_nxt;
  logic [2:0] mism;

  // Per-output mismatch for the vector under test; a cleared care bit
  // suppresses that output, so a row with no care bits can never fail.
  always_comb begin
    mism = {(F_2 ^ EXP_F2[idx]) & CARE_F2[idx],
            (F_1 ^ EXP_F1[idx]) & CARE_F1[idx],
            (F_0 ^ EXP_F0[idx]) & CARE_F0[idx]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_nxt         = state;
    idx_nxt           = idx;
    settle_cnt_nxt    = settle_cnt;
    err_cnt_nxt       = err_cnt;
    first_err_vld_nxt = first_err_vld;
    first_err_idx_nxt = first_err_idx;
    err_bits_nxt      = err_bits;

    case (state)
      // A start in DONE behaves as in IDLE: results clear on the same edge.
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt         = S_SETTLE;
          idx_nxt           = 4'd0;
          settle_cnt_nxt    = 4'd0;
          err_cnt_nxt       = 5'd0;
          first_err_vld_nxt = 1'b0;
          first_err_idx_nxt = 4'd0;
          err_bits_nxt      = 3'd0;
        end
      end

      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = S_CHECK;
        end else begin
          settle_cnt_nxt = settle_cnt + 4'd1;
        end
      end

      S_CHECK: begin
        if (mism != 3'd0) begin
          if (err_cnt != ERR_MAX) begin
            err_cnt_nxt = err_cnt + 5'd1;
          end
          if (!first_err_vld) begin
            first_err_vld_nxt = 1'b1;
            first_err_idx_nxt = idx;
            err_bits_nxt      = mism;
          end
        end
        if (idx == 4'd15) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt      = S_SETTLE;
          idx_nxt        = idx + 4'd1;
          settle_cnt_nxt = 4'd0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Drive register follows idx so ABCD change only on the edge idx changes.
    vec_nxt = idx_nxt;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= 4'd0;
      settle_cnt    <= 4'd0;
      vec_q         <= 4'd0;
      err_cnt       <= 5'd0;
      first_err_vld <= 1'b0;
      first_err_idx <= 4'd0;
      err_bits      <= 3'd0;
    end else begin
      idx           <= idx_nxt;
      settle_cnt    <= settle_cnt_nxt;
      vec_q         <= vec_nxt;
      err_cnt       <= err_cnt_nxt;
      first_err_vld <= first_err_vld_nxt;
      first_err_idx <= first_err_idx_nxt;
      err_bits      <= err_bits_nxt;
    end
  end

  assign {A, B, C, D} = vec_q;

  // Status flags decode directly from registered state, so they are glitch-free
  // relative to the clock and drop to zero together with the reset.
  assign busy = (state == S_SETTLE) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_cnt == 5'd0);

endmodule
